mem_bank: RTL and testbench

MEM_BANK -- requirements
Module: mem_bank

---
 rtl/mem_bank.sv | 146 ++++++++++++++
 tb/tb_mem_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// Word-addressed memory with byte enables and a fixed number of wait states per access.
// One access at a time; ack/err pulse in the single response cycle.
module mem_bank #(
  parameter int DWIDTH      = 32,
  parameter int ADEPTH      = 1000,
  parameter int AWIDTH      = $clog2(ADEPTH),
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int NB    = DWIDTH / 8;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WLOAD);
  localparam logic [AWIDTH:0] DEPTH    = (AWIDTH + 1)'(ADEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]     cnt;
  logic              lat_we;
  logic [AWIDTH-1:0] lat_addr;
  logic [NB-1:0]     lat_be;
  logic [DWIDTH-1:0] lat_wdata;

  logic              acc_we;
  logic [AWIDTH-1:0] acc_addr;
  logic [NB-1:0]     acc_be;
  logic [DWIDTH-1:0] acc_wdata;
  logic              in_range;
  logic              latch;
  logic              enter_resp;
  logic              mem_wr;

  logic [DWIDTH-1:0] mem [ADEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == WAIT) || (state == RESP);
    latch      = (state == IDLE) && req;
    enter_resp = (state_nxt == RESP);
  end

  // With zero wait states the access completes on the same edge it is
  // accepted, so the live inputs stand in for the not-yet-latched copies.
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_be    = lat_be;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_be    = be;
      acc_wdata = wdata;
    end
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH);
  assign mem_wr   = enter_resp && acc_we && in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (latch) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_be    <= be;
      lat_wdata <= wdata;
    end
  end

  // Storage is never reset; contents stay undefined until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_wr && acc_be[i]) begin
        mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack <= enter_resp;
      err <= enter_resp && !in_range;
      if (enter_resp && !acc_we) begin
        rdata <= in_range ? mem[acc_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// Bench for mem_bank: directed scenarios plus random accesses against a byte-level memory model.
// Two instances: default wait states and a zero-wait-state build.
module tb_mem_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;
  logic        ack, err, busy;

  logic        z_req, z_we;
  logic [9:0]  z_addr;
  logic [3:0]  z_be;
  logic [31:0] z_wdata, z_rdata;
  logic        z_ack, z_err, z_busy;

  mem_bank #(.DWIDTH(32), .ADEPTH(1000), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  mem_bank #(.DWIDTH(32), .ADEPTH(1000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(z_req), .we(z_we), .addr(z_addr), .be(z_be), .wdata(z_wdata),
    .rdata(z_rdata), .ack(z_ack), .err(z_err), .busy(z_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-instance word array with per-byte "written" flags.
  logic [31:0] model [2][1024];
  bit   [3:0]  kb    [2][1024];
  logic [31:0] last_rd [2];
  bit          lr_ok   [2];
  logic [31:0] obs_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic o_ack(input bit s);
    return s ? z_ack : ack;
  endfunction
  function automatic logic o_err(input bit s);
    return s ? z_err : err;
  endfunction
  function automatic logic o_busy(input bit s);
    return s ? z_busy : busy;
  endfunction
  function automatic logic [31:0] o_rdata(input bit s);
    return s ? z_rdata : rdata;
  endfunction

  task automatic drive(input bit s, input bit r, input bit w, input logic [9:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    if (s) begin
      z_req = r; z_we = w; z_addr = a; z_be = b; z_wdata = d;
    end else begin
      req = r; we = w; addr = a; be = b; wdata = d;
    end
  endtask

  // One full transaction: req presented right after "edge 0", expected ack
  // in the cycle after edge WAIT_CYCLES+1.
  task automatic access(input bit s, input bit w, input logic [9:0] a, input logic [3:0] b,
                        input logic [31:0] d, input string tag);
    int          lat;
    int          busy_n;
    int          ack_k;
    bit          inr;
    bit          chk;
    logic [31:0] exp_rd;
    lat = s ? 1 : 3;
    inr = (a < 10'd1000);
    chk = 1'b1;
    exp_rd = '0;
    if (w) begin
      if (inr) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) begin
            model[s][a][8*i +: 8] = d[8*i +: 8];
            kb[s][a][i] = 1'b1;
          end
        end
      end
      exp_rd = last_rd[s];
      chk = lr_ok[s];
    end else if (inr) begin
      exp_rd = model[s][a];
      chk = (kb[s][a] == 4'hF);
    end
    @(posedge clk);
    #1 drive(s, 1'b1, w, a, b, d);
    busy_n = 0;
    ack_k = 0;
    for (int k = 1; k <= 12 && ack_k == 0; k++) begin
      @(posedge clk);
      if (k == 1) begin
        #1 drive(s, 1'b0, w, a, b, d);
      end
      @(negedge clk);
      if (o_busy(s)) busy_n++;
      if (o_ack(s)) begin
        ack_k = k;
        obs_rd = o_rdata(s);
        check({tag, "_err"}, 32'(o_err(s)), 32'(!inr));
        if (chk) check({tag, "_rdata"}, obs_rd, exp_rd);
      end
    end
    check({tag, "_ack_cycle"}, 32'(ack_k), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, o_ack(s), o_busy(s)}, 32'd0);
    if (!w) begin
      last_rd[s] = exp_rd;
      lr_ok[s] = chk;
    end
  endtask

  initial begin
    int n_ack;
    int prev_k;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'd0);
    drive(1, 1'b1, 1'b0, 10'd5, 4'hF, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_main", {rdata[30:0] | {28'd0, ack, err, busy}, rdata[31]}, 32'd0);
    check("reset_z", {z_rdata[30:0] | {28'd0, z_ack, z_err, z_busy}, z_rdata[31]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    lr_ok[0] = 1'b1; lr_ok[1] = 1'b1;

    access(0, 1, 10'd5, 4'hF, 32'hDEADBEEF, "wr5");
    access(0, 0, 10'd5, 4'hF, 32'd0, "rd5");
    check("rd5_value", obs_rd, 32'hDEADBEEF);
    access(0, 1, 10'd5, 4'h5, 32'h11223344, "wr5_partial");
    access(0, 0, 10'd5, 4'h0, 32'd0, "rd5_partial");
    check("rd5_partial_value", obs_rd, 32'hDE22BE44);
    access(0, 1, 10'd5, 4'h0, 32'hFFFFFFFF, "wr5_be0");
    access(0, 0, 10'd5, 4'h0, 32'd0, "rd5_be0");
    check("rd5_be0_value", obs_rd, 32'hDE22BE44);

    access(0, 1, 10'd488, 4'hF, 32'h01880188, "wr488");
    access(0, 1, 10'd999, 4'hF, 32'h09990999, "wr999");
    access(0, 1, 10'd0,   4'hF, 32'h00000000, "wr0");
    access(0, 0, 10'd1000, 4'hF, 32'd0, "rd1000");
    check("rd1000_value", obs_rd, 32'd0);
    access(0, 1, 10'd1000, 4'hF, 32'hBAD0BAD0, "wr1000");
    access(0, 1, 10'd1023, 4'hF, 32'hBAD1BAD1, "wr1023");
    access(0, 0, 10'd488, 4'h0, 32'd0, "rd488");
    access(0, 0, 10'd999, 4'h0, 32'd0, "rd999");
    access(0, 0, 10'd0,   4'h0, 32'd0, "rd0");

    // req held high: one ack every WAIT_CYCLES+2 cycles, rest ignored.
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'd0);
    n_ack = 0;
    prev_k = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) begin
        n_ack++;
        check("stream_rdata", rdata, 32'hDE22BE44);
        check("stream_spacing", 32'(k - prev_k), (prev_k == 0) ? 32'd3 : 32'd4);
        prev_k = k;
      end
    end
    drive(0, 1'b0, 1'b0, 10'd5, 4'h0, 32'd0);
    check("stream_ack_count", 32'(n_ack), 32'd4);
    repeat (4) @(negedge clk);
    check("stream_idle", {31'd0, busy}, 32'd0);
    last_rd[0] = 32'hDE22BE44;

    // Reset aborting a write: sampled mid-WAIT (v=2) and on the RESP-entry edge (v=3).
    access(0, 1, 10'd7, 4'hF, 32'h07070707, "wr7");
    for (int v = 2; v <= 3; v++) begin
      @(posedge clk);
      #1 drive(0, 1'b1, 1'b1, 10'd7, 4'hF, 32'hCAFEF00D);
      n_ack = 0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) drive(0, 1'b0, 1'b1, 10'd7, 4'hF, 32'hCAFEF00D);
        rst = (k == v - 1);
        @(negedge clk);
        if (ack) n_ack++;
        if (k >= v) check("abort_busy", {31'd0, busy}, 32'd0);
        if (k == v) check("abort_rdata", rdata, 32'd0);
      end
      check("abort_no_ack", 32'(n_ack), 32'd0);
      last_rd[0] = '0; last_rd[1] = '0;
      lr_ok[0] = 1'b1; lr_ok[1] = 1'b1;
      access(0, 0, 10'd7, 4'h0, 32'd0, "rd7_after_abort");
      check("rd7_unchanged", obs_rd, 32'h07070707);
    end

    access(1, 1, 10'd3, 4'hF, 32'hA5A50F0F, "z_wr3");
    access(1, 0, 10'd3, 4'h0, 32'd0, "z_rd3");
    check("z_rd3_value", obs_rd, 32'hA5A50F0F);
    access(1, 1, 10'd3, 4'h6, 32'h11223344, "z_wr3_partial");
    access(1, 0, 10'd1010, 4'h0, 32'd0, "z_rd1010");
    access(1, 0, 10'd3, 4'h0, 32'd0, "z_rd3_partial");

    for (int a = 0; a < 16; a++) begin
      access(0, 1, 10'(a), 4'hF, $urandom, "fill");
    end
    for (int n = 0; n < 60; n++) begin
      logic [9:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 15));
      access(0, 1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
